// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run/step/breakpoint controller.
// The state encoding is exported so the 7-seg display mux can decode it.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_e;

    localparam int DEFAULT_DIV       = 50_000_000;
    localparam int DEFAULT_DB_CYCLES = 1_000_000;
    localparam int DEFAULT_CW        = 26;
    localparam int DEFAULT_DBW       = 20;

    function automatic logic is_halted_state(input run_state_e s);
        return (s == ST_HALT) || (s == ST_BREAK);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_pb_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability debounce and a
// one-cycle press pulse on each accepted 0->1 transition of the button.
module pb_debounce
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int DBW       = DEFAULT_DBW
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_raw,
    output logic press
);

    logic [1:0]     r_sync;
    logic           r_level;
    logic [DBW-1:0] r_cnt;
    logic           r_press;

    logic w_synced;
    logic w_differs;
    logic w_accept;

    assign w_synced  = r_sync[1];
    assign w_differs = (w_synced != r_level);
    // The synced value has disagreed with the accepted level for DB_CYCLES cycles.
    assign w_accept  = w_differs && (r_cnt == DBW'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            // NOTE: non-blocking so the second flop captures the first flop's previous value.
            r_sync <= {r_sync[0], pb_raw};

            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DBW'(1);
            end

            if (w_accept) begin
                r_level <= w_synced;
            end

            r_press <= w_accept && w_synced;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: issues one-cycle cpu_en pulses to the core
// in free-run (every DIV cycles) or single-step mode and halts on a PC match.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV       = DEFAULT_DIV,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int CW        = DEFAULT_CW,
    parameter int DBW       = DEFAULT_DBW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pb,
    input  logic        run_mode,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] step_count
);

    run_state_e    r_state;
    logic          r_cpu_en;
    logic          r_halted;
    logic          r_skip_bp;
    logic [CW-1:0] r_div;
    logic [15:0]   r_step_count;

    run_state_e    w_state_nxt;
    logic          w_cpu_en_nxt;
    logic          w_halted_nxt;
    logic          w_skip_bp_nxt;
    logic [CW-1:0] w_div_nxt;
    logic          w_press;
    logic          w_tick;
    logic          w_bp_hit;
    logic          w_unused_pc;

    pb_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DBW       (DBW)
    ) u_pb_debounce (
        .clk    (clk),
        .reset  (reset),
        .pb_raw (pb),
        .press  (w_press)
    );

    assign w_tick      = (r_div == CW'(DIV - 1));
    // skip_bp lets a restart execute the instruction sitting on the breakpoint.
    assign w_bp_hit    = bp_en && (pc[7:0] == bp_addr) && !r_skip_bp;
    assign w_unused_pc = ^pc[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_HALT;
            r_cpu_en  <= 1'b0;
            r_halted  <= 1'b1;
            r_skip_bp <= 1'b0;
            r_div     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_en  <= w_cpu_en_nxt;
            r_halted  <= w_halted_nxt;
            r_skip_bp <= w_skip_bp_nxt;
            r_div     <= w_div_nxt;
        end
    end

    // Press outranks a run_mode drop, which outranks a tick in the same cycle.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_HALT: begin
                if (w_press) begin
                    w_state_nxt = run_mode ? ST_RUN : ST_STEP;
                end
            end
            ST_RUN: begin
                if (w_press || !run_mode) begin
                    w_state_nxt = ST_HALT;
                end else if (w_tick && w_bp_hit) begin
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_HALT;
            end
            ST_BREAK: begin
                if (w_press) begin
                    w_state_nxt = ST_STEP;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    always_comb begin
        w_cpu_en_nxt  = 1'b0;
        w_skip_bp_nxt = r_skip_bp;
        w_div_nxt     = '0;
        unique case (r_state)
            ST_HALT: begin
                if (w_state_nxt == ST_RUN) begin
                    w_skip_bp_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_state_nxt == ST_RUN) begin
                    w_div_nxt = w_tick ? '0 : r_div + CW'(1);
                    if (w_tick) begin
                        w_cpu_en_nxt  = 1'b1;
                        w_skip_bp_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_skip_bp_nxt = r_skip_bp;
            end
        endcase
        if (w_state_nxt == ST_STEP) begin
            w_cpu_en_nxt = 1'b1;
        end
        w_halted_nxt = is_halted_state(w_state_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_count <= '0;
        end else if (r_cpu_en) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    assign cpu_en     = r_cpu_en;
    assign halted     = r_halted;
    assign state      = r_state;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (DIV=4, DB_CYCLES=3): stimulus table,
// directed multi-cycle sequences and random stimulus against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        pb;
    logic        run_mode;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] step_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DIV       (DIV),
        .DB_CYCLES (DB),
        .CW        (4),
        .DBW       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pb         (pb),
        .run_mode   (run_mode),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .state      (state),
        .step_count (step_count)
    );

    // Behavioural model: raw button samples age through a queue, the debounced
    // level flips after DB disagreeing samples, and RUN ticks fall on every
    // DIV-th edge counted from RUN entry.
    bit          m_hist[$];
    bit          m_level;
    int          m_unstable;
    bit          m_press;
    int          m_st;
    int          m_since;
    bit          m_skip;
    bit          m_en;
    int unsigned m_pulses;
    bit          follow;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist     = '{1'b0, 1'b0};
        m_level    = 1'b0;
        m_unstable = 0;
        m_press    = 1'b0;
        m_st       = 0;
        m_since    = 0;
        m_skip     = 1'b0;
        m_en       = 1'b0;
        m_pulses   = 0;
    endtask

    task automatic model_edge();
        bit synced;
        bit p;
        bit nxt_en;
        if (reset) begin
            model_reset();
            return;
        end
        synced = m_hist.pop_front();
        m_hist.push_back(pb);
        p       = m_press;
        m_press = 1'b0;
        if (synced != m_level) begin
            m_unstable++;
            if (m_unstable == DB) begin
                m_level    = synced;
                m_unstable = 0;
                m_press    = synced;
            end
        end else begin
            m_unstable = 0;
        end
        if (m_en) m_pulses = (m_pulses + 1) % 65536;
        nxt_en = 1'b0;
        case (m_st)
            0: if (p) begin
                if (run_mode) begin
                    m_st = 1; m_since = 0; m_skip = 1'b1;
                end else begin
                    m_st = 2; nxt_en = 1'b1;
                end
            end
            1: if (p || !run_mode) begin
                m_st = 0;
            end else begin
                m_since++;
                if (m_since % DIV == 0) begin
                    if (bp_en && pc[7:0] == bp_addr && !m_skip) begin
                        m_st = 3;
                    end else begin
                        nxt_en = 1'b1; m_skip = 1'b0;
                    end
                end
            end
            2: m_st = 0;
            default: if (p) begin
                m_st = 2; nxt_en = 1'b1;
            end
        endcase
        m_en = nxt_en;
    endtask

    task automatic compare_model();
        check("model state", 32'(state), 32'(m_st));
        check("model cpu_en", 32'(cpu_en), 32'(m_en));
        check("model halted", 32'(halted), 32'((m_st == 0) || (m_st == 3)));
        check("model step_count", 32'(step_count), m_pulses);
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare_model();
            if (follow && m_en) pc[7:0] = (pc[7:0] + 8'd4) & 8'h0C;
        end
    endtask

    task automatic expect_out(input string name, input int st, input bit en, input bit h);
        check({name, " state"}, 32'(state), 32'(st));
        check({name, " cpu_en"}, 32'(cpu_en), 32'(en));
        check({name, " halted"}, 32'(halted), 32'(h));
    endtask

    // Hold the button long enough to be accepted; press is live for the next edge.
    task automatic do_press();
        pb = 1'b1;
        cycle(5);
        pb = 1'b0;
    endtask

    typedef struct {
        bit pb;
        bit rm;
        int n;
        int st;
        bit en;
        bit h;
        int cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b1; pb = 1'b0; run_mode = 1'b0; bp_en = 1'b0;
        bp_addr = 8'h00; pc = 32'h0; follow = 1'b0;
        model_reset();
        cycle(2);
        expect_out("reset", 0, 1'b0, 1'b1);
        check("reset step_count", 32'(step_count), 32'h0);
        reset = 1'b0;

        // Idle, glitch-rejected single step, free-run with press on a tick.
        vecs.push_back('{1'b0, 1'b0, 20, 0, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b1, 1'b0, 1,  0, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 3,  0, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b1, 1'b0, 5,  0, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b1, 1'b0, 1,  2, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1,  0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 1'b0, 3,  0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 8,  0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 1'b1, 5,  0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 1'b1, 1,  1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b1, 3,  1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b1, 1,  1, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b1, 1,  1, 1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 3,  1, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 1,  1, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 1,  1, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b1, 1'b1, 5,  1, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 1'b1, 1,  0, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b0, 1'b1, 1,  0, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b0, 1'b1, 8,  0, 1'b0, 1'b1, 4});
        foreach (vecs[i]) begin
            pb = vecs[i].pb;
            run_mode = vecs[i].rm;
            cycle(vecs[i].n);
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].h);
            check($sformatf("vec%0d step_count", i), 32'(step_count), 32'(vecs[i].cnt));
        end

        // Breakpoint at 0x0C with the core stepping pc 0,4,8,C.
        bp_en = 1'b1; bp_addr = 8'h0C; pc = 32'h1234_5600; follow = 1'b1; run_mode = 1'b1;
        do_press(); cycle(1);
        expect_out("bp run entry", 1, 1'b0, 1'b0);
        cycle(12);
        expect_out("bp third pulse", 1, 1'b1, 1'b0);
        cycle(4);
        expect_out("bp hit", 3, 1'b0, 1'b1);
        follow = 1'b0;
        do_press(); cycle(1);
        expect_out("bp step", 2, 1'b1, 1'b0);
        cycle(1);
        expect_out("bp step done", 0, 1'b0, 1'b1);
        cycle(6); do_press(); cycle(1);
        expect_out("bp rerun", 1, 1'b0, 1'b0);
        cycle(4);
        expect_out("skip_bp tick", 1, 1'b1, 1'b0);
        cycle(4);
        expect_out("bp rehit", 3, 1'b0, 1'b1);

        // BREAK ignores run_mode; run_mode drop in RUN halts next cycle.
        run_mode = 1'b0;
        cycle(3);
        expect_out("break holds", 3, 1'b0, 1'b1);
        bp_en = 1'b0;
        do_press(); cycle(1);
        expect_out("break step", 2, 1'b1, 1'b0);
        cycle(7);
        run_mode = 1'b1;
        do_press(); cycle(1);
        expect_out("run again", 1, 1'b0, 1'b0);
        cycle(2);
        run_mode = 1'b0;
        cycle(1);
        expect_out("run_mode drop", 0, 1'b0, 1'b1);

        // Async reset one cycle before a tick cuts the pulse; divider restarts.
        cycle(6); run_mode = 1'b1;
        do_press(); cycle(1); cycle(3);
        expect_out("pre-reset", 1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        expect_out("async reset", 0, 1'b0, 1'b1);
        check("async reset step_count", 32'(step_count), 32'h0);
        cycle(2);
        reset = 1'b0;
        cycle(3);
        do_press(); cycle(1); cycle(3);
        expect_out("post-reset run", 1, 1'b0, 1'b0);
        cycle(1);
        expect_out("post-reset first tick", 1, 1'b1, 1'b0);
        cycle(1);
        check("post-reset step_count", 32'(step_count), 32'h1);

        // step_count wrap from a preloaded value near the top.
        run_mode = 1'b0;
        cycle(1);
        force dut.r_step_count = 16'hFFFE;
        #1;
        release dut.r_step_count;
        m_pulses = 32'hFFFE;
        cycle(6);
        run_mode = 1'b1;
        do_press(); cycle(1); cycle(8);
        check("pre-wrap step_count", 32'(step_count), 32'hFFFF);
        cycle(1);
        check("wrap step_count", 32'(step_count), 32'h0);

        // Random phase against the model.
        follow = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(399) == 0) reset = 1'b1;
            if ($urandom_range(11) == 0) pb = ~pb;
            if ($urandom_range(39) == 0) run_mode = ~run_mode;
            if ($urandom_range(49) == 0) bp_en = ~bp_en;
            if ($urandom_range(29) == 0) bp_addr = 8'($urandom_range(3) * 4);
            cycle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/breakpoint controller that sequences the MIPS core on the board.
- Generates a one-cycle clock-enable pulse (cpu_en) from the 50 MHz board clock, replacing the fixed 1 s tick.
- Supports free-run at a divided rate, single-step on the pushbutton, and halt on an 8-bit PC breakpoint.
- Sits in the top level between clock, switches, pushbutton and the core; exports state for the 7-seg display mux.

Parameters:
DIV, 50000000, clk cycles between cpu_en pulses in RUN (>=2)
DB_CYCLES, 1000000, clk cycles pb must be stable to be accepted (>=1)
CW, 26, width of divider counter (must hold DIV-1)
DBW, 20, width of debounce counter (must hold DB_CYCLES)

Ports:
clk  in  1  board clock, 50 MHz
reset  in  1  asynchronous, active-high; clears all state
pb  in  1  raw pushbutton, asynchronous to clk
run_mode  in  1  switch: 1 = free-run on press, 0 = single-step on press
bp_en  in  1  breakpoint enable
bp_addr  in  8  breakpoint address, compared to pc[7:0]
pc  in  32  current core PC
cpu_en  out  1  one-cycle enable pulse to core
halted  out  1  1 in HALT or BREAK
state  out  2  encoded FSM state
step_count  out  16  number of cpu_en pulses issued, wraps at 16'hFFFF -> 0

Behaviour:
Reset values:
- state = HALT
- cpu_en = 0
- halted = 1
- step_count = 0
- divider = 0
- debouncer cleared; press pulse = 0

Pushbutton (pb_debounce sub-module):
- pb passes through a 2-flop synchronizer.
- Debounced level updates only after the synced value differs from it for DB_CYCLES consecutive cycles.
- press = one-cycle pulse on debounced 0->1; none on release.
- Latency from clean pb rise to press: 2 + DB_CYCLES cycles.

State encoding: HALT=2'b00, RUN=2'b01, STEP=2'b10, BREAK=2'b11.

HALT:
- press && run_mode -> RUN; divider cleared to 0; skip_bp set to 1.
- press && !run_mode -> STEP.

STEP:
- cpu_en=1 for exactly this one cycle, then HALT.
- Presses during STEP are ignored.

RUN:
- Divider counts 0..DIV-1 and wraps.
- At divider==DIV-1 (tick):
  - if bp_en && pc[7:0]==bp_addr && !skip_bp: -> BREAK, no cpu_en.
  - else: cpu_en=1, clear skip_bp.
- press -> HALT, no cpu_en; press has priority over a tick in the same cycle.
- run_mode==0 -> HALT (checked after press, before tick).
- First cpu_en after entry occurs exactly DIV cycles after entering RUN.

BREAK:
- press -> STEP (one pulse moves past the breakpoint), then HALT.
- run_mode is ignored in BREAK.

Outputs and timing:
- cpu_en is registered (decoded from state/tick at the clock edge); never high two consecutive cycles when DIV>=2.
- step_count increments on every cycle cpu_en=1.
- halted = (state==HALT)||(state==BREAK), registered.
- Breakpoint compare uses pc as sampled on the tick cycle. The core updates pc on the cpu_en cycle, so pc is stable at the next tick.
- Reset asserted mid-operation: all outputs return to reset values immediately (async); a cpu_en pulse in flight is cut.

Decomposition:
- Shared package/header: state encodings (ST_HALT, ST_RUN, ST_STEP, ST_BREAK) and the default DIV/DB_CYCLES constants, so the display mux can decode state.
- One sub-module, pb_debounce (clk, reset, pb_raw -> press), parameterized by DB_CYCLES/DBW.
- FSM, divider and step counter stay in cpu_run_ctrl.

Test Plan:
(All with DIV=4, DB_CYCLES=3.)
1. Reset, hold pb low 20 cycles -> state=00, halted=1, cpu_en never asserted, step_count=0.
2. run_mode=0, pb high 10 cycles with a 1-cycle glitch before it -> glitch rejected; exactly one cpu_en 6 cycles after stable rise (2 sync + 3 DB + 1 STEP); state returns to 00; step_count=1.
3. run_mode=1, press -> cpu_en every 4 cycles starting 4 cycles after RUN entry; second press -> HALT. If the press coincides with a tick, no pulse that cycle.
4. RUN with bp_en=1, bp_addr=8'h0C, pc stepping 0,4,8,C -> at tick with pc=0C: state=11, no cpu_en. Press -> one cpu_en, then state=00. Press again with run_mode=1 -> the first tick at pc=0C is issued (skip_bp).
5. In RUN, assert reset 1 cycle before a tick -> cpu_en stays 0, state=00, step_count=0, divider restarts from 0 on next RUN entry.
6. run_mode 1->0 while in RUN -> HALT next cycle; step_count wrap: preload via 65536 pulses -> 0.
